climate_ctrl: RTL
=================

Name: climate_ctrl

Overview:
- Control stage directly downstream of the DHT11 reader in the cold-storage design.
- Consumes temperature/humidity samples, validates them and watches for sensor timeout.
- Drives the cooling-fan and humidifier outputs (led_fan/led_hum) with hysteresis and minimum dwell.
- Supports auto/manual mode. Fails safe to fan on, humidifier off when the sensor goes stale.

Parameters:
TICK_DIV, 100_000_000, clk cycles per control tick (1 s at 100 MHz)
TEMP_HI, 8, deg C; auto fan turns on when temp >= TEMP_HI
TEMP_LO, 4, deg C; auto fan turns off when temp <= TEMP_LO
HUM_LO, 85, %RH; auto humidifier turns on when hum <= HUM_LO
HUM_HI, 92, %RH; auto humidifier turns off when hum >= HUM_HI
MIN_DWELL, 30, ticks an actuator must hold a state before an auto change
STALE_TICKS, 5, ticks without an accepted sample before sensor_fault

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
temperature  input  8  integer deg C from DHT11 stage
humidity  input  8  integer %RH from DHT11 stage
data_valid  input  1  one-cycle pulse; temperature/humidity valid this cycle
mode_manual  input  1  1 = manual, 0 = auto
man_fan  input  1  manual fan request
man_hum  input  1  manual humidifier request
fan_on  output  1  cooling fan drive
hum_on  output  1  humidifier drive
sensor_fault  output  1  sensor stale
sample_reject  output  1  one-cycle pulse: out-of-range sample discarded

Behaviour:
- Reset (async assert, sync release):
  - fan_on=0, hum_on=0, sensor_fault=0, sample_reject=0.
  - Latched t_q=0, h_q=0, have_sample=0; tick counter=0; stale counter=0.
  - Both dwell counters = MIN_DWELL (saturated), so the first auto decision is not blocked.
- Tick: counter 0..TICK_DIV-1; tick is a one-cycle pulse on wrap.
- Sample acceptance on data_valid:
  - Accept if temperature<=50 and humidity<=100. Latch t_q/h_q next cycle, set have_sample, clear stale counter.
  - Otherwise pulse sample_reject next cycle; latched values and stale counter unchanged.
- Stale timer:
  - Increments on tick, saturating at STALE_TICKS.
  - sensor_fault=1 while the counter equals STALE_TICKS.
  - Accept and tick in the same cycle: accept wins, counter=0.
- Dwell counters: one per actuator. Increment on tick, saturate at MIN_DWELL; cleared to 0 in the cycle the actuator output changes.
- Per-actuator FSM, states OFF/ON, evaluated every cycle; priority order:
  1. mode_manual=1: output follows man_fan/man_hum with 1-cycle latency; no dwell check.
  2. Auto and sensor_fault=1: fan forced ON, hum forced OFF next cycle; no dwell check.
  3. Auto, have_sample=1, no fault:
     - Fan: OFF->ON when t_q>=TEMP_HI and dwell==MIN_DWELL; ON->OFF when t_q<=TEMP_LO and dwell==MIN_DWELL; otherwise hold.
     - Humidifier: OFF->ON when h_q<=HUM_LO; ON->OFF when h_q>=HUM_HI; same dwell rule.
  4. Auto, have_sample=0, no fault: hold OFF.
- Latency: data_valid at cycle N -> t_q valid at N+1 -> fan_on changes at N+2 (dwell permitting).
- Manual->auto switch: FSM resumes from the current output state; the dwell counter is not reset by the mode switch itself.
- Fault clear: the next accepted sample clears the fault, after which the auto rules apply with the current dwell counter.

Optional Feature:
CLIMATE_DWELL_EN
- Defined: MIN_DWELL enforcement as above.
- Undefined: dwell counters removed; auto transitions occur on threshold alone, 2 cycles after data_valid. Hysteresis is still applied.

Test Plan:
All scenarios use TICK_DIV=10, MIN_DWELL=3, STALE_TICKS=5.
- Reset: hold rst_n=0, apply data_valid with temperature=20 -> fan_on=0, hum_on=0, sensor_fault=0, t_q stays 0. Assert rst_n=0 mid-run with fan_on=1 -> fan_on=0 the same cycle (async).
- Hysteresis: after 40 cycles, valid temperature=9, humidity=90 -> fan_on=1 at N+2, hum_on=0. After dwell, temperature=6 -> fan holds 1. Then temperature=4 -> fan_on=0 at N+2. Humidity=85 -> hum_on=1; humidity=91 -> hum holds; humidity=92 -> hum_on=0.
- Dwell: temperature=9 then temperature=3 five cycles later -> fan_on stays 1 until 3 ticks (~30 cycles) after rising, then drops to 0. With CLIMATE_DWELL_EN undefined, it drops at N+2 of the second sample.
- Range reject: humidity=101, temperature=20 -> sample_reject pulses for 1 cycle; h_q/t_q unchanged; stale counter keeps running.
- Stale/fault: no accepted sample for 5 ticks -> sensor_fault=1, fan_on=1, hum_on=0 on the next cycle regardless of dwell. A valid sample with temperature=2, humidity=88 then clears the fault; fan_on=0 only after the dwell is satisfied.
- Manual: mode_manual=1, man_fan=0, man_hum=1 while temperature=9 -> fan_on=0, hum_on=1 the next cycle. Return to auto -> fan_on=1 once dwell is satisfied.

Source files
------------

// File: rtl/climate_ctrl.sv
// Cold-storage climate control: validates DHT11 samples and drives fan/humidifier with hysteresis.
// Optional `CLIMATE_DWELL_EN enables minimum-dwell enforcement on automatic actuator changes.
module climate_ctrl #(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned TEMP_HI     = 8,
  parameter int unsigned TEMP_LO     = 4,
  parameter int unsigned HUM_LO      = 85,
  parameter int unsigned HUM_HI      = 92,
  parameter int unsigned MIN_DWELL   = 30,
  parameter int unsigned STALE_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] temperature,
  input  logic [7:0] humidity,
  input  logic       data_valid,
  input  logic       mode_manual,
  input  logic       man_fan,
  input  logic       man_hum,
  output logic       fan_on,
  output logic       hum_on,
  output logic       sensor_fault,
  output logic       sample_reject
);

  localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned STALE_W = $clog2(STALE_TICKS + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_TICKS);
  localparam logic [7:0]         T_HI      = 8'(TEMP_HI);
  localparam logic [7:0]         T_LO      = 8'(TEMP_LO);
  localparam logic [7:0]         H_LO      = 8'(HUM_LO);
  localparam logic [7:0]         H_HI      = 8'(HUM_HI);
  localparam logic [7:0]         T_MAX     = 8'd50;
  localparam logic [7:0]         H_MAX     = 8'd100;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } act_state_t;

  logic [TICK_W-1:0]  tick_cnt;
  logic [STALE_W-1:0] stale_cnt;
  logic [STALE_W-1:0] stale_nxt;
  logic [7:0]         t_q;
  logic [7:0]         h_q;
  logic               have_sample;
  logic               tick_c;
  logic               in_range_c;
  logic               accept_c;
  logic               fan_set_c;
  logic               fan_clr_c;
  logic               hum_set_c;
  logic               hum_clr_c;
  logic               fan_chg_c;
  logic               hum_chg_c;
  logic               fan_dwell_ok_c;
  logic               hum_dwell_ok_c;
  act_state_t         fan_st;
  act_state_t         hum_st;

  // Control tick: one-cycle pulse every TICK_DIV clocks
  assign tick_c = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign in_range_c = (temperature <= T_MAX) && (humidity <= H_MAX);
  assign accept_c   = data_valid && in_range_c;

  // Sample latch and reject pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q           <= '0;
      h_q           <= '0;
      have_sample   <= 1'b0;
      sample_reject <= 1'b0;
    end else begin
      sample_reject <= data_valid && !in_range_c;
      if (accept_c) begin
        t_q         <= temperature;
        h_q         <= humidity;
        have_sample <= 1'b1;
      end
    end
  end

  // Stale timer: an accept in the same cycle as a tick wins
  always_comb begin
    stale_nxt = stale_cnt;
    if (accept_c) begin
      stale_nxt = '0;
    end else if (tick_c && (stale_cnt != STALE_MAX)) begin
      stale_nxt = stale_cnt + STALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stale_cnt    <= '0;
      sensor_fault <= 1'b0;
    end else begin
      stale_cnt    <= stale_nxt;
      sensor_fault <= (stale_nxt == STALE_MAX);
    end
  end

  assign fan_chg_c = (fan_st == ST_OFF) ? fan_set_c : fan_clr_c;
  assign hum_chg_c = (hum_st == ST_OFF) ? hum_set_c : hum_clr_c;

`ifdef CLIMATE_DWELL_EN
  localparam int unsigned DWELL_W = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MIN_DWELL);

  logic [DWELL_W-1:0] fan_dwell;
  logic [DWELL_W-1:0] hum_dwell;

  assign fan_dwell_ok_c = (fan_dwell == DWELL_MAX);
  assign hum_dwell_ok_c = (hum_dwell == DWELL_MAX);

  // Dwell counters restart whenever their actuator output toggles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fan_dwell <= DWELL_MAX;
      hum_dwell <= DWELL_MAX;
    end else begin
      if (fan_chg_c) begin
        fan_dwell <= '0;
      end else if (tick_c && !fan_dwell_ok_c) begin
        fan_dwell <= fan_dwell + DWELL_W'(1);
      end
      if (hum_chg_c) begin
        hum_dwell <= '0;
      end else if (tick_c && !hum_dwell_ok_c) begin
        hum_dwell <= hum_dwell + DWELL_W'(1);
      end
    end
  end
`else
  assign fan_dwell_ok_c = 1'b1;
  assign hum_dwell_ok_c = 1'b1;
`endif

  // Transition requests: manual, then fail-safe, then auto hysteresis
  always_comb begin
    fan_set_c = 1'b0;
    fan_clr_c = 1'b0;
    hum_set_c = 1'b0;
    hum_clr_c = 1'b0;
    if (mode_manual) begin
      fan_set_c = man_fan;
      fan_clr_c = !man_fan;
      hum_set_c = man_hum;
      hum_clr_c = !man_hum;
    end else if (sensor_fault) begin
      fan_set_c = 1'b1;
      hum_clr_c = 1'b1;
    end else if (have_sample) begin
      fan_set_c = (t_q >= T_HI) && fan_dwell_ok_c;
      fan_clr_c = (t_q <= T_LO) && fan_dwell_ok_c;
      hum_set_c = (h_q <= H_LO) && hum_dwell_ok_c;
      hum_clr_c = (h_q >= H_HI) && hum_dwell_ok_c;
    end
  end

  // Per-actuator OFF/ON state machines with registered drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fan_st <= ST_OFF;
      hum_st <= ST_OFF;
      fan_on <= 1'b0;
      hum_on <= 1'b0;
    end else begin
      case (fan_st)
        ST_OFF: if (fan_set_c) begin
          fan_st <= ST_ON;
          fan_on <= 1'b1;
        end
        ST_ON: if (fan_clr_c) begin
          fan_st <= ST_OFF;
          fan_on <= 1'b0;
        end
      endcase
      case (hum_st)
        ST_OFF: if (hum_set_c) begin
          hum_st <= ST_ON;
          hum_on <= 1'b1;
        end
        ST_ON: if (hum_clr_c) begin
          hum_st <= ST_OFF;
          hum_on <= 1'b0;
        end
      endcase
    end
  end

endmodule
